// File: rtl/store_merge_buffer.sv
// store_merge_buffer: aligning, merging store FIFO feeding the dcache write port; define SMB_FORWARD_EN for load forwarding
module store_merge_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [ADDR_W-1:0]          st_addr_i,
  input  logic [1:0]                 st_size_i,
  input  logic [31:0]                st_data_i,
  output logic                       st_misalign_o,
  output logic                       dr_valid_o,
  input  logic                       dr_ready_i,
  output logic [ADDR_W-3:0]          dr_addr_o,
  output logic [31:0]                dr_data_o,
  output logic [3:0]                 dr_strb_o,
  input  logic [ADDR_W-3:0]          ld_addr_i,
  output logic [31:0]                ld_fwd_data_o,
  output logic [3:0]                 ld_fwd_mask_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int WA = ADDR_W-2;
  if (DATA_W != 32) begin : g_data_w_check
    $error("store_merge_buffer supports DATA_W=32 only");
  end
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WA-1:0]    addr_q [DEPTH];
  logic [WA-1:0]    addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [3:0]       strb_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, hit_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             mis_q, mis_d, hit, mis, acc, alloc, merge, pop;
  logic [1:0]       off;
  logic [WA-1:0]    st_wa;
  logic [3:0]       st_strb;
  logic [31:0]      st_sdata;
  assign off      = st_addr_i[1:0];
  assign st_wa    = st_addr_i[ADDR_W-1:2];
  assign mis      = (st_size_i == 2'b11) | ((st_size_i == 2'b01) & off[0]) | ((st_size_i == 2'b10) & (off != 2'b00));
  assign st_strb  = st_size_i == 2'b00 ? 4'b0001 << off : st_size_i == 2'b01 ? 4'b0011 << off : 4'hF;
  assign st_sdata = st_data_i << {off, 3'b000};
  // find a queued non-head entry holding the store's word
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && PW'(i) != head_q && addr_q[i] == st_wa) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
  end
  assign st_ready_o    = hit | mis | (count_q < CW'(DEPTH));
  assign acc           = st_valid_i & st_ready_o;
  assign alloc         = acc & ~mis & ~hit;
  assign merge         = acc & ~mis & hit;
  assign dr_valid_o    = count_q != '0;
  assign pop           = dr_valid_o & dr_ready_i;
  assign empty_o       = count_q == '0;
  assign count_o       = count_q;
  assign st_misalign_o = mis_q;
  assign dr_addr_o     = addr_q[head_q];
  assign dr_data_o     = data_q[head_q];
  assign dr_strb_o     = strb_q[head_q];
  assign head_d  = pop ? (head_q == PW'(DEPTH-1) ? '0 : head_q + PW'(1)) : head_q;
  assign tail_d  = alloc ? (tail_q == PW'(DEPTH-1) ? '0 : tail_q + PW'(1)) : tail_q;
  assign count_d = (alloc & ~pop) ? count_q + CW'(1) : (pop & ~alloc) ? count_q - CW'(1) : count_q;
  assign mis_d   = acc & mis;
  // entry next-state: retire head, write tail, or merge lanes into the hit entry
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    strb_d = strb_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (alloc) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = st_wa;
      data_d[tail_q] = st_sdata;
      strb_d[tail_q] = st_strb;
    end
    if (merge) begin
      for (int b = 0; b < 4; b++)
        if (st_strb[b]) data_d[hit_idx][8*b +: 8] = st_sdata[8*b +: 8];
      strb_d[hit_idx] = strb_q[hit_idx] | st_strb;
    end
  end
  // control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end
  // payload storage is qualified by vld_q and needs no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end
`ifdef SMB_FORWARD_EN
  // walk entries oldest to youngest so the youngest writer of each lane wins
  always_comb begin
    int k;
    k             = 0;
    ld_fwd_mask_o = '0;
    ld_fwd_data_o = '0;
    for (int j = 0; j < DEPTH; j++) begin
      k = int'(head_q) + j;
      if (k >= DEPTH) k = k - DEPTH;
      if (vld_q[k] && addr_q[k] == ld_addr_i)
        for (int b = 0; b < 4; b++)
          if (strb_q[k][b]) begin
            ld_fwd_mask_o[b]         = 1'b1;
            ld_fwd_data_o[8*b +: 8]  = data_q[k][8*b +: 8];
          end
    end
  end
`else
  logic unused_ld;
  assign unused_ld     = ^ld_addr_i;
  assign ld_fwd_mask_o = 4'h0;
  assign ld_fwd_data_o = 32'h0;
`endif
endmodule

// File: tb/tb_store_merge_buffer.sv
// tb_store_merge_buffer: directed self-checking bench for store_merge_buffer
module tb_store_merge_buffer;
  logic        clk;
  logic        rst_n;
  logic        st_valid_i, st_ready_o, st_misalign_o;
  logic [31:0] st_addr_i, st_data_i;
  logic [1:0]  st_size_i;
  logic        dr_valid_o, dr_ready_i;
  logic [29:0] dr_addr_o, ld_addr_i;
  logic [31:0] dr_data_o, ld_fwd_data_o;
  logic [3:0]  dr_strb_o, ld_fwd_mask_o;
  logic [2:0]  count_o;
  logic        empty_o;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  store_merge_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_size_i(st_size_i), .st_data_i(st_data_i), .st_misalign_o(st_misalign_o),
    .dr_valid_o(dr_valid_o), .dr_ready_i(dr_ready_i), .dr_addr_o(dr_addr_o),
    .dr_data_o(dr_data_o), .dr_strb_o(dr_strb_o),
    .ld_addr_i(ld_addr_i), .ld_fwd_data_o(ld_fwd_data_o), .ld_fwd_mask_o(ld_fwd_mask_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_size_i  = s;
    st_data_i  = d;
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic pop1;
    dr_ready_i = 1'b1;
    tick();
    dr_ready_i = 1'b0;
  endtask

  task automatic mis_case(input string tag, input logic [31:0] a, input logic [1:0] s);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_size_i  = s;
    st_data_i  = 32'hFFFF_FFFF;
    #1;
    chk({tag, "_ready"}, st_ready_o, 1);
    tick();
    st_valid_i = 1'b0;
    chk({tag, "_pulse"}, st_misalign_o, 1);
    chk({tag, "_count"}, count_o, 0);
    tick();
    chk({tag, "_pulse_end"}, st_misalign_o, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    st_valid_i = 1'b0;
    st_addr_i  = '0;
    st_size_i  = '0;
    st_data_i  = '0;
    dr_ready_i = 1'b0;
    ld_addr_i  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    // T1: reset with pending stores
    st(32'h100, 2'b10, 32'h1);
    st(32'h200, 2'b10, 32'h2);
    chk("t1_pre_count", count_o, 2);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("t1_count", count_o, 0);
    chk("t1_dr_valid", dr_valid_o, 0);
    chk("t1_empty", empty_o, 1);
    chk("t1_misalign", st_misalign_o, 0);
    tick();
    chk("t1_count_after", count_o, 0);
    // T2: alignment and latency
    st(32'h1003, 2'b00, 32'hAB);
    chk("t2_dr_valid", dr_valid_o, 1);
    chk("t2_strb", dr_strb_o, 4'b1000);
    chk("t2_data", dr_data_o, 32'hAB00_0000);
    chk("t2_addr", dr_addr_o, 30'h400);
    st(32'h2002, 2'b01, 32'h1234);
    chk("t2_count2", count_o, 2);
    chk("t2_head_stable", dr_strb_o, 4'b1000);
    pop1();
    chk("t2_h_strb", dr_strb_o, 4'b1100);
    chk("t2_h_data", dr_data_o, 32'h1234_0000);
    chk("t2_h_addr", dr_addr_o, 30'h800);
    chk("t2_count1", count_o, 1);
    pop1();
    chk("t2_empty", empty_o, 1);
    // T3: merge into non-head, head immutability
    st(32'h3000, 2'b10, 32'hAAAA_AAAA);
    st(32'h4003, 2'b00, 32'h99);
    st(32'h4001, 2'b00, 32'h55);
    st(32'h4002, 2'b01, 32'h6677);
    chk("t3_merge_count", count_o, 2);
    st(32'h3001, 2'b00, 32'h77);
    chk("t3_alloc_head_word", count_o, 3);
    chk("t3_head_addr", dr_addr_o, 30'hC00);
    chk("t3_head_strb", dr_strb_o, 4'hF);
    chk("t3_head_data", dr_data_o, 32'hAAAA_AAAA);
    pop1();
    chk("t3_b_addr", dr_addr_o, 30'h1000);
    chk("t3_b_strb", dr_strb_o, 4'b1110);
    chk("t3_b_data", dr_data_o, 32'h6677_5500);
    pop1();
    chk("t3_a2_addr", dr_addr_o, 30'hC00);
    chk("t3_a2_strb", dr_strb_o, 4'b0010);
    chk("t3_a2_data", dr_data_o, 32'h0000_7700);
    pop1();
    chk("t3_count0", count_o, 0);
    // T4: full, hit while full, drain order across the wrap
    for (int i = 0; i < 4; i++) st(32'h5000 + 32'(4*i), 2'b10, 32'hD0 + 32'(i));
    chk("t4_full_count", count_o, 4);
    st_valid_i = 1'b1;
    st_addr_i  = 32'h6000;
    st_size_i  = 2'b10;
    st_data_i  = 32'hEE;
    #1;
    chk("t4_full_ready", st_ready_o, 0);
    dr_ready_i = 1'b1;
    #1;
    chk("t4_full_pop_ready", st_ready_o, 0);
    dr_ready_i = 1'b0;
    st_addr_i  = 32'h5008;
    #1;
    chk("t4_hit_ready", st_ready_o, 1);
    tick();
    st_valid_i = 1'b0;
    chk("t4_hit_count", count_o, 4);
    dr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_addr", dr_addr_o, 30'h1400 + 30'(i));
      chk("t4_drain_data", dr_data_o, i == 2 ? 32'hEE : 32'hD0 + 32'(i));
      tick();
    end
    dr_ready_i = 1'b0;
    chk("t4_drained", empty_o, 1);
    for (int i = 0; i < 4; i++) st(32'h7000 + 32'(4*i), 2'b10, 32'h70 + 32'(i));
    chk("t4_refill_count", count_o, 4);
    dr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_wrap_addr", dr_addr_o, 30'h1C00 + 30'(i));
      chk("t4_wrap_data", dr_data_o, 32'h70 + 32'(i));
      tick();
    end
    dr_ready_i = 1'b0;
    chk("t4_wrap_empty", count_o, 0);
    // T5: misaligned and reserved sizes
    mis_case("t5_sh_off1", 32'h8001, 2'b01);
    mis_case("t5_sw_off2", 32'h8002, 2'b10);
    mis_case("t5_size11", 32'h8000, 2'b11);
    // T6: load forwarding
    st(32'h9000, 2'b00, 32'h11);
    st(32'h9000, 2'b01, 32'h2233);
    ld_addr_i = 30'h2400;
    #1;
`ifdef SMB_FORWARD_EN
    chk("t6_mask", ld_fwd_mask_o, 4'b0011);
    chk("t6_data", ld_fwd_data_o, 32'h0000_2233);
`else
    chk("t6_mask_off", ld_fwd_mask_o, 4'h0);
    chk("t6_data_off", ld_fwd_data_o, 32'h0);
`endif
    st_valid_i = 1'b1;
    st_addr_i  = 32'h9003;
    st_size_i  = 2'b00;
    st_data_i  = 32'h44;
    #1;
`ifdef SMB_FORWARD_EN
    chk("t6_same_cycle_hidden", ld_fwd_mask_o, 4'b0011);
`else
    chk("t6_same_cycle_off", ld_fwd_mask_o, 4'h0);
`endif
    tick();
    st_valid_i = 1'b0;
`ifdef SMB_FORWARD_EN
    chk("t6_merged_mask", ld_fwd_mask_o, 4'b1011);
    chk("t6_merged_data", ld_fwd_data_o, 32'h4400_2233);
`else
    chk("t6_merged_mask_off", ld_fwd_mask_o, 4'h0);
    chk("t6_merged_data_off", ld_fwd_data_o, 32'h0);
`endif
    ld_addr_i = 30'h2401;
    #1;
    chk("t6_miss_mask", ld_fwd_mask_o, 4'h0);
    chk("t6_count", count_o, 2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
